// File: rtl/nn_param_loader_pkg.sv
// Shared constants for the WVCNN parameter loader.
// Holds the default dimensions, the lane-offset width and the loader state encoding.
// The default depths come from the per-layer row table that the SRAM wrapper also uses,
// so the loader and the wrapper agree on where the weight and bias regions end.
package nn_param_loader_pkg;

    localparam int unsigned LDR_WIDTH = 12;
    localparam int unsigned LDR_N     = 5;
    localparam int unsigned LDR_ADR_W = 13;

    // Width of the lane-offset field on the memory-config interface.
    localparam int unsigned LANE_W    = 5;

    // Per-layer row counts. These are the same numbers the SRAM wrapper uses for its layer offsets.
    localparam int unsigned L0_WEIGHT_ROWS = 1024;
    localparam int unsigned L1_WEIGHT_ROWS = 2048;
    localparam int unsigned L2_WEIGHT_ROWS = 2048;
    localparam int unsigned L3_WEIGHT_ROWS = 1024;
    localparam int unsigned L0_BIAS_ROWS   = 64;
    localparam int unsigned L1_BIAS_ROWS   = 96;
    localparam int unsigned L2_BIAS_ROWS   = 64;
    localparam int unsigned L3_BIAS_ROWS   = 32;

    localparam int unsigned DEF_WEIGHT_DEPTH =
        L0_WEIGHT_ROWS + L1_WEIGHT_ROWS + L2_WEIGHT_ROWS + L3_WEIGHT_ROWS;
    localparam int unsigned DEF_BIAS_DEPTH =
        L0_BIAS_ROWS + L1_BIAS_ROWS + L2_BIAS_ROWS + L3_BIAS_ROWS;

    typedef enum logic [1:0] {
        LDR_STA_IDLE   = 2'd0,
        LDR_STA_WEIGHT = 2'd1,
        LDR_STA_BIAS   = 2'd2,
        LDR_STA_DONE   = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/nn_param_loader_cnt.sv
// Row/lane counter pair for the parameter loader.
// Ports: clk, rst_n; clear (synchronous clear), advance (one word accepted),
//        bias_phase (1 = bias rows, lane pinned to 0); row, lane (current write position);
//        terminal_c (combinational: the current position is the last one of the phase).
module nn_param_loader_cnt
    import nn_param_loader_pkg::*;
#(
    parameter int unsigned N            = LDR_N,
    parameter int unsigned ADR_W        = LDR_ADR_W,
    parameter int unsigned WEIGHT_DEPTH = DEF_WEIGHT_DEPTH,
    parameter int unsigned BIAS_DEPTH   = DEF_BIAS_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic              bias_phase,
    output logic [ADR_W-1:0]  row,
    output logic [LANE_W-1:0] lane,
    output logic              terminal_c
);

    logic lane_last_c;

    assign lane_last_c = (lane == LANE_W'(N - 1));

    // Last write position of the current phase.
    always_comb begin
        terminal_c = 1'b0;
        if (bias_phase) begin
            terminal_c = (row == ADR_W'(BIAS_DEPTH - 1));
        end else begin
            terminal_c = lane_last_c && (row == ADR_W'(WEIGHT_DEPTH - 1));
        end
    end

    // Lane wraps at N in the weight phase; a phase end clears both counters for the next phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row  <= '0;
            lane <= '0;
        end else if (clear || (advance && terminal_c)) begin
            row  <= '0;
            lane <= '0;
        end else if (advance) begin
            if (bias_phase) begin
                row  <= row + ADR_W'(1);
                lane <= '0;
            end else if (lane_last_c) begin
                row  <= row + ADR_W'(1);
                lane <= '0;
            end else begin
                lane <= lane + LANE_W'(1);
            end
        end
    end

endmodule

// File: rtl/nn_param_loader.sv
// Parameter loader: unpacks a valid/ready stream of parameter words into the SRAM wrapper's
// memory-config interface. Weight words come first, N per row; bias words follow, one per row.
// Ports: clk, rst_n; start_i (load request, IDLE only), abort_i (synchronous abort);
//        word_i/word_valid_i/word_ready_o (input stream); mem_wr_req_o (hold main FSM in MEMWR);
//        mem_ram_dest_o/mem_ram_adr_o/mem_ram_adr_offset_o/mem_ram_data_o (registered write);
//        busy_o (not IDLE); done_o (one-cycle pulse after the last bias write).
module nn_param_loader
    import nn_param_loader_pkg::*;
#(
    parameter int unsigned WIDTH             = LDR_WIDTH,
    parameter int unsigned N                 = LDR_N,
    parameter int unsigned MEM_ADR_MAX_WIDTH = LDR_ADR_W,
    parameter int unsigned WEIGHT_DEPTH      = DEF_WEIGHT_DEPTH,
    parameter int unsigned BIAS_DEPTH        = DEF_BIAS_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [WIDTH-1:0]             word_i,
    input  logic                         word_valid_i,
    output logic                         word_ready_o,
    output logic                         mem_wr_req_o,
    output logic                         mem_ram_dest_o,
    output logic [MEM_ADR_MAX_WIDTH-1:0] mem_ram_adr_o,
    output logic [LANE_W-1:0]            mem_ram_adr_offset_o,
    output logic [WIDTH-1:0]             mem_ram_data_o,
    output logic                         busy_o,
    output logic                         done_o
);

    // Parameter sanity checks at elaboration.
    if ((WEIGHT_DEPTH > (1 << MEM_ADR_MAX_WIDTH)) || (BIAS_DEPTH > (1 << MEM_ADR_MAX_WIDTH)))
    begin : g_bad_depth
        $error("nn_param_loader: depth does not fit in MEM_ADR_MAX_WIDTH address bits");
    end
    if ((N * WIDTH > 60) || (N == 0) || (N > (1 << LANE_W))) begin : g_bad_row
        $error("nn_param_loader: N*WIDTH must be <= 60 and N must fit the lane offset");
    end

    ldr_state_t                   state;
    ldr_state_t                   state_nxt;
    logic                         accept_c;
    logic                         cnt_clear_c;
    logic                         terminal_c;
    logic [MEM_ADR_MAX_WIDTH-1:0] row;
    logic [LANE_W-1:0]            lane;

    // Status outputs decode the state register directly.
    assign word_ready_o = (state == LDR_STA_WEIGHT) || (state == LDR_STA_BIAS);
    assign mem_wr_req_o = (state != LDR_STA_IDLE);
    assign busy_o       = (state != LDR_STA_IDLE);
    assign done_o       = (state == LDR_STA_DONE);

    // Abort takes priority over an accept in the same cycle.
    assign accept_c    = word_valid_i && word_ready_o && !abort_i;
    assign cnt_clear_c = abort_i || ((state == LDR_STA_IDLE) && start_i);

    nn_param_loader_cnt #(
        .N            (N),
        .ADR_W        (MEM_ADR_MAX_WIDTH),
        .WEIGHT_DEPTH (WEIGHT_DEPTH),
        .BIAS_DEPTH   (BIAS_DEPTH)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear_c),
        .advance    (accept_c),
        .bias_phase (state == LDR_STA_BIAS),
        .row        (row),
        .lane       (lane),
        .terminal_c (terminal_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LDR_STA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = LDR_STA_IDLE;
        end else begin
            case (state)
                LDR_STA_IDLE:   if (start_i) state_nxt = LDR_STA_WEIGHT;
                LDR_STA_WEIGHT: if (accept_c && terminal_c) state_nxt = LDR_STA_BIAS;
                LDR_STA_BIAS:   if (accept_c && terminal_c) state_nxt = LDR_STA_DONE;
                LDR_STA_DONE:   state_nxt = LDR_STA_IDLE;
                default:        state_nxt = LDR_STA_IDLE;
            endcase
        end
    end

    // Write payload; holds between accepts so the SRAM rewrites the same lane harmlessly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ram_dest_o       <= 1'b0;
            mem_ram_adr_o        <= '0;
            mem_ram_adr_offset_o <= '0;
            mem_ram_data_o       <= '0;
        end else if (accept_c) begin
            mem_ram_dest_o       <= (state == LDR_STA_WEIGHT);
            mem_ram_adr_o        <= row;
            mem_ram_adr_offset_o <= lane;
            mem_ram_data_o       <= word_i;
        end
    end

endmodule

// File: tb/tb_nn_param_loader.sv
// Scoreboard bench for nn_param_loader with a small configuration (N=5, WIDTH=12, 2 weight rows,
// 3 bias rows). The driver pushes the expected write for every word it sees accepted; a separate
// monitor pops and compares after each accepting edge and mirrors mem_wr_req_o writes into an SRAM image.
module tb_nn_param_loader;

    localparam int unsigned WIDTH  = 12;
    localparam int unsigned N      = 5;
    localparam int unsigned AW     = 13;
    localparam int unsigned WD     = 2;
    localparam int unsigned BD     = 3;
    localparam int unsigned NWORDS = WD * N + BD;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [WIDTH-1:0] word_i = '0;
    logic             word_valid_i = 1'b0;
    logic             word_ready_o;
    logic             mem_wr_req_o;
    logic             mem_ram_dest_o;
    logic [AW-1:0]    mem_ram_adr_o;
    logic [4:0]       mem_ram_adr_offset_o;
    logic [WIDTH-1:0] mem_ram_data_o;
    logic             busy_o;
    logic             done_o;

    nn_param_loader #(
        .WIDTH             (WIDTH),
        .N                 (N),
        .MEM_ADR_MAX_WIDTH (AW),
        .WEIGHT_DEPTH      (WD),
        .BIAS_DEPTH        (BD)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_i              (start_i),
        .abort_i              (abort_i),
        .word_i               (word_i),
        .word_valid_i         (word_valid_i),
        .word_ready_o         (word_ready_o),
        .mem_wr_req_o         (mem_wr_req_o),
        .mem_ram_dest_o       (mem_ram_dest_o),
        .mem_ram_adr_o        (mem_ram_adr_o),
        .mem_ram_adr_offset_o (mem_ram_adr_offset_o),
        .mem_ram_data_o       (mem_ram_data_o),
        .busy_o               (busy_o),
        .done_o               (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             dest;
        logic [AW-1:0]    adr;
        logic [4:0]       off;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t              exp_q[$];
    wr_t              last_exp;
    int               chk_cnt  = 0;
    int               pass_cnt = 0;
    int               done_cnt = 0;
    int               acc_cnt  = 0;
    int               load_idx = 0;
    logic [WIDTH-1:0] wimg [WD][N];
    logic [WIDTH-1:0] bimg [BD];
    logic [WIDTH-1:0] words [NWORDS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic wr_t cur_out();
        wr_t r;
        r.dest = mem_ram_dest_o;
        r.adr  = mem_ram_adr_o;
        r.off  = mem_ram_adr_offset_o;
        r.data = mem_ram_data_o;
        return r;
    endfunction

    // Reference placement of the k-th word of a load: first WD*N words fill weight rows lane by lane,
    // the rest go to consecutive bias rows at lane 0.
    function automatic wr_t model(input int k, input logic [WIDTH-1:0] w);
        wr_t r;
        if (k < int'(WD * N)) begin
            r.dest = 1'b1;
            r.adr  = AW'(k / int'(N));
            r.off  = 5'(k % int'(N));
        end else begin
            r.dest = 1'b0;
            r.adr  = AW'(k - int'(WD * N));
            r.off  = 5'd0;
        end
        r.data = w;
        return r;
    endfunction

    // Monitor: SRAM image write on every edge with mem_wr_req_o high; scoreboard pop on each accept.
    initial begin
        logic acc;
        int   a;
        int   o;
        wr_t  e;
        forever begin
            @(posedge clk);
            acc = rst_n && word_valid_i && word_ready_o && !abort_i;
            if (rst_n && mem_wr_req_o) begin
                a = int'(mem_ram_adr_o);
                o = int'(mem_ram_adr_offset_o);
                if (mem_ram_dest_o) begin
                    if (a < int'(WD) && o < int'(N)) wimg[a][o] = mem_ram_data_o;
                end else if (a < int'(BD)) begin
                    bimg[a] = mem_ram_data_o;
                end
            end
            #2;
            if (done_o) done_cnt++;
            if (acc) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_payload", 32'(cur_out()), 32'(e));
                end
            end
        end
    end

    // Present one word and wait (bounded) until it is accepted; called and returns at a negedge.
    task automatic send(input logic [WIDTH-1:0] w);
        int waited = 0;
        word_i       = w;
        word_valid_i = 1'b1;
        #1;
        while (!word_ready_o) begin
            if (waited > 20) begin
                check("ready_timeout", 32'd0, 32'd1);
                word_valid_i = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
            #1;
        end
        last_exp = model(load_idx, w);
        exp_q.push_back(last_exp);
        load_idx++;
        @(negedge clk);
        word_valid_i = 1'b0;
    endtask

    // One idle cycle with junk on word_i; the write payload must not move.
    task automatic gap();
        word_valid_i = 1'b0;
        word_i       = WIDTH'($urandom);
        @(posedge clk);
        #2;
        check("gap_stable", 32'(cur_out()), 32'(last_exp));
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start_i = 1'b1;
        @(posedge clk);
        #2;
        check("start_status", {29'd0, busy_o, mem_wr_req_o, word_ready_o}, 32'd7);
        @(negedge clk);
        start_i  = 1'b0;
        load_idx = 0;
    endtask

    task automatic run_load(input bit gapped, input bit directed, input bit poke);
        int d0;
        int a0;
        for (int k = 0; k < int'(NWORDS); k++)
            words[k] = directed ? WIDTH'(k + 1) : WIDTH'($urandom);
        for (int r = 0; r < int'(WD); r++)
            for (int l = 0; l < int'(N); l++) wimg[r][l] = 'x;
        for (int r = 0; r < int'(BD); r++) bimg[r] = 'x;
        d0 = done_cnt;
        do_start();
        a0 = acc_cnt;
        for (int k = 0; k < int'(NWORDS); k++) begin
            send(words[k]);
            if (poke && k == 2) begin
                start_i = 1'b1;
                @(negedge clk);
                start_i = 1'b0;
            end
            if (gapped && k < int'(NWORDS) - 1) gap();
        end
        // Cycle after the last accept: DONE.
        check("done_cycle", {28'd0, done_o, busy_o, mem_wr_req_o, word_ready_o}, 32'he);
        @(negedge clk);
        check("after_done", {28'd0, done_o, busy_o, mem_wr_req_o, word_ready_o}, 32'h0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("accept_count", 32'(acc_cnt - a0), 32'(NWORDS));
        for (int r = 0; r < int'(WD); r++)
            for (int l = 0; l < int'(N); l++)
                check($sformatf("weight_r%0d_l%0d", r, l), 32'(wimg[r][l]), 32'(words[r * int'(N) + l]));
        for (int r = 0; r < int'(BD); r++)
            check($sformatf("bias_r%0d", r), 32'(bimg[r]), 32'(words[int'(WD * N) + r]));
    endtask

    initial begin
        wr_t snap;
        int  d0;

        // Reset state.
        #12;
        check("reset_payload", 32'(cur_out()), 32'd0);
        check("reset_status", {28'd0, done_o, busy_o, mem_wr_req_o, word_ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Valid words in IDLE are ignored.
        snap = cur_out();
        word_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            word_i = WIDTH'($urandom);
            @(posedge clk);
            #2;
            check("idle_no_accept", {30'd0, busy_o, word_ready_o}, 32'd0);
            check("idle_payload", 32'(cur_out()), 32'(snap));
            @(negedge clk);
        end
        word_valid_i = 1'b0;

        // Back-to-back directed load, then gapped directed load, then random load with a stray start.
        run_load(1'b0, 1'b1, 1'b0);
        run_load(1'b1, 1'b1, 1'b0);
        run_load(1'b0, 1'b0, 1'b1);

        // Abort after 7 accepts, with a competing valid word in the abort cycle.
        d0 = done_cnt;
        do_start();
        for (int k = 0; k < 7; k++) send(WIDTH'($urandom));
        abort_i      = 1'b1;
        word_valid_i = 1'b1;
        word_i       = WIDTH'($urandom);
        @(posedge clk);
        #2;
        check("abort_status", {28'd0, done_o, busy_o, mem_wr_req_o, word_ready_o}, 32'd0);
        check("abort_payload_kept", 32'(cur_out()), 32'(last_exp));
        @(negedge clk);
        abort_i      = 1'b0;
        word_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        run_load(1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges while in the bias phase.
        do_start();
        for (int k = 0; k < int'(WD * N) + 1; k++) send(WIDTH'($urandom));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_payload", 32'(cur_out()), 32'd0);
        check("async_rst_status", {28'd0, done_o, busy_o, mem_wr_req_o, word_ready_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_load(1'b0, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
